// File: rtl/ca_pkg.sv
// Shared pipeline-control types: register address width and stall sequencer states.
package ca_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MISS = 2'd1,
        FILL = 2'd2
    } stall_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the EX-stage load and the ID-stage source registers.
module hazard_detect
    import ca_pkg::*;
(
    input  logic                  idex_memread_i,
    input  logic [REG_ADDR_W-1:0] idex_rd_i,
    input  logic [REG_ADDR_W-1:0] ifid_rs1_i,
    input  logic [REG_ADDR_W-1:0] ifid_rs2_i,
    output logic                  load_use_o
);

    // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
    assign load_use_o = idex_memread_i
                     && (idex_rd_i != '0)
                     && ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer: merges load-use, branch flush and data-miss refill into the
// pipeline register enables, with a refill watchdog and a saturating stall counter.
module pipeline_stall_ctrl
    import ca_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  idex_memread_i,
    input  logic [REG_ADDR_W-1:0] idex_rd_i,
    input  logic [REG_ADDR_W-1:0] ifid_rs1_i,
    input  logic [REG_ADDR_W-1:0] ifid_rs2_i,
    input  logic                  dmem_req_i,
    input  logic                  dmem_hit_i,
    input  logic                  mem_ack_i,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  ifid_flush_o,
    output logic                  idex_bubble_o,
    output logic                  pipe_stall_o,
    output logic                  mem_req_o,
    output logic                  refill_we_o,
    output logic                  err_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    localparam int                WDOG_W    = $clog2(TIMEOUT);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    stall_state_t      state_q;
    logic [WDOG_W-1:0] wdog_q;
    logic              memReq_q;
    logic              refillWe_q;
    logic              err_q;
    logic [CNT_W-1:0]  stallCnt_q;
    logic [CNT_W-1:0]  stallCnt_d;

    logic loadUse;
    logic miss;
    logic stallAll;
    logic stallCycle;

    hazard_detect u_hazard_detect (
        .idex_memread_i (idex_memread_i),
        .idex_rd_i      (idex_rd_i),
        .ifid_rs1_i     (ifid_rs1_i),
        .ifid_rs2_i     (ifid_rs2_i),
        .load_use_o     (loadUse)
    );

    // A miss freezes the pipe in the very cycle it is seen, before the FSM leaves RUN.
    assign miss       = (state_q == RUN) && dmem_req_i && !dmem_hit_i;
    assign stallAll   = (state_q != RUN) || miss;
    assign stallCycle = stallAll || loadUse;

    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        if (stallAll) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end else if (loadUse) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end else if (flush_i) begin
            ifid_flush_o = 1'b1;
        end
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (stallCycle && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

    // The watchdog only flags the stuck refill; the request stays up so a late ack still completes it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            wdog_q     <= '0;
            memReq_q   <= 1'b0;
            refillWe_q <= 1'b0;
            err_q      <= 1'b0;
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
            case (state_q)
                RUN: begin
                    wdog_q     <= '0;
                    refillWe_q <= 1'b0;
                    memReq_q   <= miss;
                    if (miss) begin
                        state_q <= MISS;
                    end
                end
                MISS: begin
                    if (mem_ack_i) begin
                        state_q    <= FILL;
                        memReq_q   <= 1'b0;
                        refillWe_q <= 1'b1;
                        wdog_q     <= '0;
                    end else if (wdog_q == WDOG_LAST) begin
                        err_q  <= 1'b1;
                        wdog_q <= '0;
                    end else begin
                        wdog_q <= wdog_q + WDOG_W'(1);
                    end
                end
                FILL: begin
                    state_q    <= RUN;
                    refillWe_q <= 1'b0;
                end
                default: begin
                    state_q    <= RUN;
                    memReq_q   <= 1'b0;
                    refillWe_q <= 1'b0;
                    wdog_q     <= '0;
                end
            endcase
        end
    end

    assign pipe_stall_o = stallAll;
    assign mem_req_o    = memReq_q;
    assign refill_we_o  = refillWe_q;
    assign err_o        = err_q;
    assign stall_cnt_o  = stallCnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with a cycle-level behavioural model checked every cycle.
module tb_pipeline_stall_ctrl;

    localparam int TB_TIMEOUT = 4;
    localparam int TB_CNT_W   = 3;
    localparam int SAT        = (1 << TB_CNT_W) - 1;

    logic                clk;
    logic                rst;
    logic                flush;
    logic                memread;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic                dreq;
    logic                dhit;
    logic                ack;
    logic                pcWrite;
    logic                ifidWrite;
    logic                ifidFlush;
    logic                idexBubble;
    logic                pipeStall;
    logic                memReq;
    logic                refillWe;
    logic                err;
    logic [TB_CNT_W-1:0] stallCnt;

    int checks   = 0;
    int failures = 0;

    // Model: where the refill is, how long the request has gone unanswered, total stall cycles.
    bit modelLive   = 1'b0;
    bit mInMiss     = 1'b0;
    bit mInFill     = 1'b0;
    bit mErr        = 1'b0;
    int mMissCycles = 0;
    int mStallTotal = 0;

    pipeline_stall_ctrl #(
        .TIMEOUT (TB_TIMEOUT),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .idex_memread_i (memread),
        .idex_rd_i      (rd),
        .ifid_rs1_i     (rs1),
        .ifid_rs2_i     (rs2),
        .dmem_req_i     (dreq),
        .dmem_hit_i     (dhit),
        .mem_ack_i      (ack),
        .pc_write_o     (pcWrite),
        .ifid_write_o   (ifidWrite),
        .ifid_flush_o   (ifidFlush),
        .idex_bubble_o  (idexBubble),
        .pipe_stall_o   (pipeStall),
        .mem_req_o      (memReq),
        .refill_we_o    (refillWe),
        .err_o          (err),
        .stall_cnt_o    (stallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %b, required %b (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkCount(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic bit modelLoadUse();
        return memread && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

    function automatic bit modelStall();
        return mInMiss || mInFill || (dreq && !dhit);
    endfunction

    task automatic checkOutput();
        bit lu;
        bit st;
        lu = modelLoadUse();
        st = modelStall();
        checkBit("model.pipe_stall",  pipeStall,  st);
        checkBit("model.pc_write",    pcWrite,    !st && !lu);
        checkBit("model.ifid_write",  ifidWrite,  !st && !lu);
        checkBit("model.idex_bubble", idexBubble, !st && lu);
        checkBit("model.ifid_flush",  ifidFlush,  !st && !lu && flush);
        checkBit("model.mem_req",     memReq,     mInMiss);
        checkBit("model.refill_we",   refillWe,   mInFill);
        checkBit("model.err",         err,        mErr);
        checkCount("model.stall_cnt", 32'(stallCnt), (mStallTotal > SAT) ? SAT : mStallTotal);
    endtask

    task automatic updateModel();
        if (rst) begin
            modelLive   = 1'b1;
            mInMiss     = 1'b0;
            mInFill     = 1'b0;
            mErr        = 1'b0;
            mMissCycles = 0;
            mStallTotal = 0;
        end else begin
            if (modelStall() || modelLoadUse()) mStallTotal++;
            if (mInFill) begin
                mInFill = 1'b0;
            end else if (mInMiss) begin
                if (ack) begin
                    mInMiss = 1'b0;
                    mInFill = 1'b1;
                end else begin
                    mMissCycles++;
                    if (mMissCycles >= TB_TIMEOUT) mErr = 1'b1;
                end
            end else if (dreq && !dhit) begin
                mInMiss     = 1'b1;
                mMissCycles = 0;
            end
        end
    endtask

    task automatic applyStimulus(input int r, input int f, input int mr, input int d,
                                 input int s1, input int s2, input int rq, input int ht,
                                 input int ak);
        rst     = (r != 0);
        flush   = (f != 0);
        memread = (mr != 0);
        rd      = 5'(d);
        rs1     = 5'(s1);
        rs2     = 5'(s2);
        dreq    = (rq != 0);
        dhit    = (ht != 0);
        ack     = (ak != 0);
        @(negedge clk);
        if (modelLive) checkOutput();
    endtask

    task automatic endCycle();
        @(posedge clk);
        updateModel();
        #1;
    endtask

    task automatic cycle(input int r, input int f, input int mr, input int d,
                         input int s1, input int s2, input int rq, input int ht,
                         input int ak);
        applyStimulus(r, f, mr, d, s1, s2, rq, ht, ak);
        endCycle();
    endtask

    initial begin
        cycle(1, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 1, 0);
        checkBit("reset.mem_req", memReq, 1'b0);
        checkBit("reset.refill_we", refillWe, 1'b0);
        checkBit("reset.err", err, 1'b0);
        checkCount("reset.stall_cnt", 32'(stallCnt), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkBit("reset.pc_write", pcWrite, 1'b1);
        checkBit("reset.pipe_stall", pipeStall, 1'b0);
        endCycle();

        applyStimulus(0, 0, 1, 5, 5, 0, 0, 0, 0);
        checkBit("lu.pc_write", pcWrite, 1'b0);
        checkBit("lu.ifid_write", ifidWrite, 1'b0);
        checkBit("lu.bubble", idexBubble, 1'b1);
        endCycle();
        checkCount("lu.stall_cnt", 32'(stallCnt), 1);
        applyStimulus(0, 0, 0, 5, 5, 0, 0, 0, 0);
        checkBit("lu.release_pc_write", pcWrite, 1'b1);
        endCycle();

        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        checkBit("x0.pc_write", pcWrite, 1'b1);
        checkBit("x0.bubble", idexBubble, 1'b0);
        endCycle();
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
        checkBit("flush.ifid_flush", ifidFlush, 1'b1);
        checkBit("flush.pc_write", pcWrite, 1'b1);
        endCycle();
        checkCount("flush.stall_cnt", 32'(stallCnt), 1);
        applyStimulus(0, 0, 1, 7, 3, 7, 0, 0, 0);
        checkBit("rs2.bubble", idexBubble, 1'b1);
        endCycle();

        applyStimulus(0, 1, 1, 9, 9, 0, 0, 0, 0);
        checkBit("luflush.bubble", idexBubble, 1'b1);
        checkBit("luflush.ifid_flush", ifidFlush, 1'b0);
        checkBit("luflush.pc_write", pcWrite, 1'b0);
        endCycle();
        checkCount("luflush.stall_cnt", 32'(stallCnt), 3);

        cycle(1, 0, 0, 0, 0, 0, 0, 1, 0);
        checkCount("rst2.stall_cnt", 32'(stallCnt), 0);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkBit("miss.first_stall", pipeStall, 1'b1);
        checkBit("miss.first_mem_req", memReq, 1'b0);
        endCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, (i == 2) ? 1 : 0);
            checkBit("miss.mem_req", memReq, 1'b1);
            checkBit("miss.stall", pipeStall, 1'b1);
            checkBit("miss.flush_ignored", ifidFlush, 1'b0);
            endCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1);
        checkBit("fill.refill_we", refillWe, 1'b1);
        checkBit("fill.mem_req", memReq, 1'b0);
        checkBit("fill.stall", pipeStall, 1'b1);
        endCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0);
        checkBit("replay.stall", pipeStall, 1'b0);
        checkBit("replay.refill_we", refillWe, 1'b0);
        checkCount("replay.stall_cnt", 32'(stallCnt), 5);
        endCycle();
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 1);
        checkBit("ackrun.mem_req", memReq, 1'b0);

        cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkBit("wdog.err_early", err, 1'b0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkBit("wdog.err", err, 1'b1);
        checkBit("wdog.mem_req", memReq, 1'b1);
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0);
        checkBit("wdog.err_sticky", err, 1'b1);
        checkBit("wdog.back_to_run", pipeStall, 1'b0);
        checkCount("wdog.stall_cnt_sat", 32'(stallCnt), 7);
        endCycle();

        cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
        checkBit("rstmiss.mem_req", memReq, 1'b0);
        checkCount("rstmiss.stall_cnt", 32'(stallCnt), 0);
        checkBit("rstmiss.err", err, 1'b0);
        checkBit("rstmiss.pc_write", pcWrite, 1'b1);
        endCycle();
        checkBit("rstmiss.no_refill", refillWe, 1'b0);

        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 1, 12, 4, 12, 0, 0, 0);
            if (i == 6) checkCount("sat.reach7", 32'(stallCnt), 7);
        end
        checkCount("sat.hold7", 32'(stallCnt), 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
